// File: rtl/sipo_frame_rx_if.sv
// Serial receive bundle: line and enable into the framer, deframed word and status flags out.
// The master side drives the line and the enable; the slave side is the receiver.
interface sipo_frame_rx_if #(
  parameter int DATA_BITS = 8
);
  logic                 rx_en;
  logic                 data_tx;
  logic [DATA_BITS-1:0] data_out;
  logic                 valid;
  logic                 parity_err;
  logic                 frame_err;
  logic                 break_det;
  logic                 active_flag;

  modport master (
    output rx_en, data_tx,
    input  data_out, valid, parity_err, frame_err, break_det, active_flag
  );

  modport slave (
    input  rx_en, data_tx,
    output data_out, valid, parity_err, frame_err, break_det, active_flag
  );
endinterface

// File: rtl/sipo_frame_rx.sv
// Oversampled UART deframer: 2-of-3 mid-bit vote, LSB-first shift, parity/stop checks, one-cycle valid.
// Word is delivered at the vote of the last stop bit; the line cannot be stalled, so there is no backpressure.
module sipo_frame_rx #(
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int PARITY_EN  = 1,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input logic           baud_clk,
  input logic           rst_n,
  sipo_frame_rx_if.slave rx
);

  if (OVERSAMPLE < 8 || OVERSAMPLE > 32 || (OVERSAMPLE % 2) != 0) begin : g_bad_os
    $error("sipo_frame_rx: OVERSAMPLE must be even and in 8..32");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_db
    $error("sipo_frame_rx: DATA_BITS must be in 5..9");
  end
  if (PARITY_EN < 0 || PARITY_EN > 1 || PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_par
    $error("sipo_frame_rx: PARITY_EN and PARITY_ODD must be 0 or 1");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
    $error("sipo_frame_rx: STOP_BITS must be 1 or 2");
  end

  localparam int CW = $clog2(OVERSAMPLE);
  localparam int M  = OVERSAMPLE / 2;
  localparam logic [CW-1:0] C_V0   = CW'(M - 1);
  localparam logic [CW-1:0] C_V1   = CW'(M);
  localparam logic [CW-1:0] C_DEC  = CW'(M + 1);
  localparam logic [CW-1:0] C_END  = CW'(OVERSAMPLE - 1);
  localparam logic [3:0]    LAST_D = 4'(DATA_BITS - 1);
  localparam logic [3:0]    LAST_S = 4'(STOP_BITS - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_HI} state_t;

  state_t               state, state_next;
  logic [CW-1:0]        cnt, cnt_next;
  logic [3:0]           bidx, bidx_next;
  logic                 s0, s1, vote;
  logic                 decide, bit_end;
  logic                 store_data, store_par, store_stop, complete;
  logic [DATA_BITS-1:0] shreg;
  logic                 perr_acc, ferr_acc, any_one;
  logic [DATA_BITS-1:0] data_out_r;
  logic                 valid_r, parity_err_r, frame_err_r, break_det_r;

  assign vote    = (s0 & s1) | (s0 & rx.data_tx) | (s1 & rx.data_tx);
  assign decide  = (cnt == C_DEC);
  assign bit_end = (cnt == C_END);

  always_ff @(posedge baud_clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      bidx  <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      bidx  <= bidx_next;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt + CW'(1);
    bidx_next  = bidx;
    store_data = 1'b0;
    store_par  = 1'b0;
    store_stop = 1'b0;
    complete   = 1'b0;
    if (!rx.rx_en) begin
      state_next = IDLE;
      cnt_next   = '0;
      bidx_next  = '0;
    end else begin
      case (state)
        IDLE: begin
          cnt_next  = '0;
          bidx_next = '0;
          // The falling edge itself is sample 0 of the start bit.
          if (!rx.data_tx) begin
            state_next = START;
            cnt_next   = CW'(1);
          end
        end
        START: begin
          if (decide && vote) begin
            state_next = IDLE;
            cnt_next   = '0;
          end else if (bit_end) begin
            state_next = DATA;
            cnt_next   = '0;
          end
        end
        DATA: begin
          store_data = decide;
          if (bit_end) begin
            cnt_next = '0;
            if (bidx == LAST_D) begin
              bidx_next  = '0;
              state_next = (PARITY_EN != 0) ? PARITY : STOP;
            end else begin
              bidx_next = bidx + 4'd1;
            end
          end
        end
        PARITY: begin
          store_par = decide;
          if (bit_end) begin
            cnt_next   = '0;
            state_next = STOP;
          end
        end
        STOP: begin
          store_stop = decide;
          // Finish on the last stop vote so a start on the very next sample is seen.
          if (decide && bidx == LAST_S) begin
            complete   = 1'b1;
            cnt_next   = '0;
            bidx_next  = '0;
            state_next = (ferr_acc || !vote) ? WAIT_HI : IDLE;
          end else if (bit_end) begin
            cnt_next  = '0;
            bidx_next = bidx + 4'd1;
          end
        end
        WAIT_HI: begin
          cnt_next = '0;
          if (rx.data_tx) state_next = IDLE;
        end
        default: begin
          state_next = IDLE;
          cnt_next   = '0;
          bidx_next  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge baud_clk or negedge rst_n) begin
    if (!rst_n) begin
      s0           <= 1'b0;
      s1           <= 1'b0;
      shreg        <= '0;
      perr_acc     <= 1'b0;
      ferr_acc     <= 1'b0;
      any_one      <= 1'b0;
      data_out_r   <= '0;
      valid_r      <= 1'b0;
      parity_err_r <= 1'b0;
      frame_err_r  <= 1'b0;
      break_det_r  <= 1'b0;
    end else begin
      valid_r <= 1'b0;
      if (cnt == C_V0) s0 <= rx.data_tx;
      if (cnt == C_V1) s1 <= rx.data_tx;
      if (state == IDLE) begin
        perr_acc <= 1'b0;
        ferr_acc <= 1'b0;
        any_one  <= 1'b0;
      end
      if (store_data) begin
        shreg   <= {vote, shreg[DATA_BITS-1:1]};
        any_one <= any_one | vote;
      end
      if (store_par) begin
        perr_acc <= ((^shreg) ^ vote) != 1'(PARITY_ODD);
        any_one  <= any_one | vote;
      end
      if (store_stop) begin
        ferr_acc <= ferr_acc | ~vote;
        any_one  <= any_one | vote;
      end
      if (complete) begin
        data_out_r   <= shreg;
        parity_err_r <= (PARITY_EN != 0) && perr_acc;
        frame_err_r  <= ferr_acc | ~vote;
        break_det_r  <= ~(any_one | vote);
        valid_r      <= 1'b1;
      end
    end
  end

  assign rx.data_out    = data_out_r;
  assign rx.valid       = valid_r;
  assign rx.parity_err  = parity_err_r;
  assign rx.frame_err   = frame_err_r;
  assign rx.break_det   = break_det_r;
  assign rx.active_flag = (state != IDLE);

endmodule

// File: tb/tb_sipo_frame_rx.sv
// Directed bench for sipo_frame_rx: an 8E1 receiver and an 8N1 receiver, both at OVERSAMPLE=16.
module tb_sipo_frame_rx;

  logic baud_clk = 1'b0;
  logic rst_n;
  always #5 baud_clk = ~baud_clk;

  sipo_frame_rx_if #(.DATA_BITS(8)) ife ();
  sipo_frame_rx_if #(.DATA_BITS(8)) ifn ();

  sipo_frame_rx #(.OVERSAMPLE(16), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) u_e (
    .baud_clk(baud_clk), .rst_n(rst_n), .rx(ife)
  );
  sipo_frame_rx #(.OVERSAMPLE(16), .DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u_n (
    .baud_clk(baud_clk), .rst_n(rst_n), .rx(ifn)
  );

  int vec = 0;
  int mis = 0;

  logic       vld_log [0:1023];
  logic       act_log [0:1023];
  logic [7:0] dat_log [0:1023];
  logic [2:0] flg_log [0:1023];
  logic [7:0] imm_dat;
  logic       imm_any;

  // Line image: bit 0 = start, then data LSB first, parity, stop.
  function automatic logic [31:0] mk_e(input logic [7:0] d, input logic p);
    return {21'd0, 1'b1, p, d, 1'b0};
  endfunction

  function automatic int count_valid(input int n);
    int c = 0;
    for (int i = 0; i < n; i++) if (vld_log[i] === 1'b1) c++;
    return c;
  endfunction

  // Drives one sample per edge k; edge k=0 is the first edge that sees the start bit.
  task automatic run_wave(input int sel, input logic [31:0] bits, input int nbits, input int low_until,
                          input int ncyc, input int rst_k, input int en_k);
    for (int k = 0; k < ncyc; k++) begin
      logic line;
      line = (k < low_until) ? 1'b0 : (((k / 16) < nbits) ? bits[k / 16] : 1'b1);
      if (sel == 0) ife.data_tx = line;
      else          ifn.data_tx = line;
      if (en_k >= 0 && k >= en_k) begin
        ife.rx_en = 1'b0;
        ifn.rx_en = 1'b0;
      end
      if (rst_k >= 0 && k == rst_k) begin
        rst_n = 1'b0;
        #1;
        imm_dat = ife.data_out;
        imm_any = ife.valid | ife.parity_err | ife.frame_err | ife.break_det | ife.active_flag;
      end
      if (rst_k >= 0 && k == rst_k + 1) rst_n = 1'b1;
      @(posedge baud_clk);
      #1;
      if (sel == 0) begin
        vld_log[k] = ife.valid;
        act_log[k] = ife.active_flag;
        dat_log[k] = ife.data_out;
        flg_log[k] = {ife.parity_err, ife.frame_err, ife.break_det};
      end else begin
        vld_log[k] = ifn.valid;
        act_log[k] = ifn.active_flag;
        dat_log[k] = ifn.data_out;
        flg_log[k] = {ifn.parity_err, ifn.frame_err, ifn.break_det};
      end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    ife.rx_en = 1'b1; ife.data_tx = 1'b1;
    ifn.rx_en = 1'b1; ifn.data_tx = 1'b1;
    repeat (3) @(posedge baud_clk);
    #1;
    vec++; if (ife.data_out !== 8'h00) begin mis++; $display("FAIL reset_data_e got=%h exp=00", ife.data_out); end
    vec++; if ({ife.valid, ife.parity_err, ife.frame_err, ife.break_det, ife.active_flag} !== 5'b0) begin
      mis++; $display("FAIL reset_flags_e got=%b exp=00000",
                      {ife.valid, ife.parity_err, ife.frame_err, ife.break_det, ife.active_flag}); end
    vec++; if ({ifn.data_out, ifn.valid, ifn.parity_err, ifn.frame_err, ifn.break_det, ifn.active_flag} !== 13'b0) begin
      mis++; $display("FAIL reset_n got=%h exp=0",
                      {ifn.data_out, ifn.valid, ifn.parity_err, ifn.frame_err, ifn.break_det, ifn.active_flag}); end
    rst_n = 1'b1;
    repeat (4) @(posedge baud_clk);
    #1;
  endtask

  task automatic test_frame_ok;
    run_wave(0, mk_e(8'hA5, 1'b0), 11, 0, 180, -1, -1);
    vec++; if (count_valid(180) !== 1) begin mis++; $display("FAIL ok_nvalid got=%0d exp=1", count_valid(180)); end
    vec++; if (vld_log[169] !== 1'b1) begin mis++; $display("FAIL ok_valid_k169 got=%b exp=1", vld_log[169]); end
    vec++; if (dat_log[169] !== 8'hA5) begin mis++; $display("FAIL ok_data got=%h exp=a5", dat_log[169]); end
    vec++; if (flg_log[169] !== 3'b000) begin mis++; $display("FAIL ok_flags got=%b exp=000", flg_log[169]); end
    vec++; if (act_log[0] !== 1'b1 || act_log[168] !== 1'b1 || act_log[169] !== 1'b0) begin
      mis++; $display("FAIL ok_active got=%b%b%b exp=110", act_log[0], act_log[168], act_log[169]); end
  endtask

  task automatic test_parity_err;
    run_wave(0, mk_e(8'hA5, 1'b1), 11, 0, 180, -1, -1);
    vec++; if (vld_log[169] !== 1'b1 || count_valid(180) !== 1) begin
      mis++; $display("FAIL par_valid got=%b/%0d exp=1/1", vld_log[169], count_valid(180)); end
    vec++; if (dat_log[169] !== 8'hA5) begin mis++; $display("FAIL par_data got=%h exp=a5", dat_log[169]); end
    vec++; if (flg_log[169] !== 3'b100) begin mis++; $display("FAIL par_flags got=%b exp=100", flg_log[169]); end
  endtask

  task automatic test_glitch;
    run_wave(0, 32'd0, 0, 2, 40, -1, -1);
    vec++; if (count_valid(40) !== 0) begin mis++; $display("FAIL glitch_nvalid got=%0d exp=0", count_valid(40)); end
    vec++; if (act_log[8] !== 1'b1 || act_log[9] !== 1'b0 || act_log[39] !== 1'b0) begin
      mis++; $display("FAIL glitch_active got=%b%b%b exp=100", act_log[8], act_log[9], act_log[39]); end
    vec++; if (dat_log[39] !== 8'hA5 || flg_log[39] !== 3'b100) begin
      mis++; $display("FAIL glitch_hold got=%h/%b exp=a5/100", dat_log[39], flg_log[39]); end
  endtask

  task automatic test_rx_en_abort;
    run_wave(0, mk_e(8'h0F, 1'b0), 11, 0, 180, -1, 80);
    vec++; if (count_valid(180) !== 0) begin mis++; $display("FAIL en_nvalid got=%0d exp=0", count_valid(180)); end
    vec++; if (act_log[79] !== 1'b1 || act_log[80] !== 1'b0) begin
      mis++; $display("FAIL en_active got=%b%b exp=10", act_log[79], act_log[80]); end
    vec++; if (dat_log[179] !== 8'hA5 || flg_log[179] !== 3'b100) begin
      mis++; $display("FAIL en_hold got=%h/%b exp=a5/100", dat_log[179], flg_log[179]); end
    ife.rx_en = 1'b1;
    ifn.rx_en = 1'b1;
  endtask

  task automatic test_clean_55;
    run_wave(0, mk_e(8'h55, 1'b0), 11, 0, 180, -1, -1);
    vec++; if (vld_log[169] !== 1'b1 || count_valid(180) !== 1) begin
      mis++; $display("FAIL c55_valid got=%b/%0d exp=1/1", vld_log[169], count_valid(180)); end
    vec++; if (dat_log[169] !== 8'h55 || flg_log[169] !== 3'b000) begin
      mis++; $display("FAIL c55_word got=%h/%b exp=55/000", dat_log[169], flg_log[169]); end
  endtask

  task automatic test_reset_abort;
    // 0xF1 keeps the line high after the reset so no spurious start follows.
    run_wave(0, mk_e(8'hF1, 1'b1), 11, 0, 180, 80, -1);
    vec++; if (imm_dat !== 8'h00 || imm_any !== 1'b0) begin
      mis++; $display("FAIL rst_immediate got=%h/%b exp=00/0", imm_dat, imm_any); end
    vec++; if (count_valid(180) !== 0) begin mis++; $display("FAIL rst_nvalid got=%0d exp=0", count_valid(180)); end
    vec++; if (dat_log[179] !== 8'h00 || act_log[179] !== 1'b0) begin
      mis++; $display("FAIL rst_after got=%h/%b exp=00/0", dat_log[179], act_log[179]); end
  endtask

  task automatic test_break;
    run_wave(0, 32'd0, 0, 528, 700, -1, -1);
    vec++; if (count_valid(700) !== 1 || vld_log[169] !== 1'b1) begin
      mis++; $display("FAIL brk_valid got=%0d/%b exp=1/1", count_valid(700), vld_log[169]); end
    vec++; if (dat_log[169] !== 8'h00 || flg_log[169] !== 3'b011) begin
      mis++; $display("FAIL brk_word got=%h/%b exp=00/011", dat_log[169], flg_log[169]); end
    vec++; if (act_log[527] !== 1'b1 || act_log[528] !== 1'b0) begin
      mis++; $display("FAIL brk_wait_hi got=%b%b exp=10", act_log[527], act_log[528]); end
  endtask

  task automatic test_back_to_back;
    logic [31:0] b;
    b = {12'd0, 1'b1, 8'hC3, 1'b0, 1'b1, 8'h3C, 1'b0};
    run_wave(1, b, 20, 0, 330, -1, -1);
    vec++; if (count_valid(330) !== 2 || vld_log[153] !== 1'b1 || vld_log[313] !== 1'b1) begin
      mis++; $display("FAIL b2b_valid got=%0d/%b/%b exp=2/1/1", count_valid(330), vld_log[153], vld_log[313]); end
    vec++; if (dat_log[153] !== 8'h3C || flg_log[153] !== 3'b000) begin
      mis++; $display("FAIL b2b_first got=%h/%b exp=3c/000", dat_log[153], flg_log[153]); end
    vec++; if (dat_log[313] !== 8'hC3 || flg_log[313] !== 3'b000) begin
      mis++; $display("FAIL b2b_second got=%h/%b exp=c3/000", dat_log[313], flg_log[313]); end
  endtask

  initial begin
    test_reset();
    test_frame_ok();
    test_parity_err();
    test_glitch();
    test_rx_en_abort();
    test_clean_55();
    test_reset_abort();
    test_clean_55();
    test_break();
    test_clean_55();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vec, mis);
    $finish;
  end

endmodule
